// File: rtl/banco_registros_sinc.sv
// banco_registros_sinc: 2^A x N register file with one write port, two registered
// read ports with write-to-read bypass, and a one-word-per-cycle bulk-clear engine.
// Optional build macro ZERO_REG_HARDWIRED_EN makes word 0 read as constant zero
// and discards writes to it.
module banco_registros_sinc #(
  parameter int unsigned N = 16,
  parameter int unsigned A = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         w,
  input  logic [A-1:0] select_register,
  input  logic [N-1:0] s,
  input  logic [A-1:0] rsel_a,
  input  logic [A-1:0] rsel_b,
  input  logic         clr,
  output logic [N-1:0] ra,
  output logic [N-1:0] rb,
  output logic         busy,
  output logic         done,
  output logic         w_lost
);

  localparam int unsigned DEPTH = 1 << A;
  localparam logic [A-1:0] LastAddr = '1;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e       state_q, state_d;
  logic [A-1:0] ptr_q, ptr_d;
  logic [N-1:0] mem_q [DEPTH];
  logic [N-1:0] ra_q, ra_d, rb_q, rb_d;
  logic         done_q, done_d;
  logic         w_lost_q, w_lost_d;

  logic         busy_now;
  logic         wr_addr_ok;
  logic         rd_ok_a, rd_ok_b;
  logic         wr_en;

`ifdef ZERO_REG_HARDWIRED_EN
  // Word 0 is a hardwired zero: never written, always read as 0, never bypassed.
  assign wr_addr_ok = (select_register != '0);
  assign rd_ok_a    = (rsel_a != '0);
  assign rd_ok_b    = (rsel_b != '0);
`else
  assign wr_addr_ok = 1'b1;
  assign rd_ok_a    = 1'b1;
  assign rd_ok_b    = 1'b1;
`endif

  assign busy_now = (state_q == StClear);
  assign wr_en    = w & ~busy_now & wr_addr_ok;

  // Clear FSM next state, done pulse and dropped-write flag.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    done_d   = 1'b0;
    w_lost_d = w & busy_now & wr_addr_ok;
    unique case (state_q)
      StIdle: begin
        if (clr) begin
          state_d = StClear;
          ptr_d   = '0;
        end
      end
      StClear: begin
        // Pointer stops at the last word instead of wrapping; clr is ignored here.
        if (ptr_q == LastAddr) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Read ports: zero while clearing, else bypass a same-edge write, else stored word.
  always_comb begin
    ra_d = '0;
    rb_d = '0;
    if (!busy_now) begin
      if (rd_ok_a) begin
        ra_d = (wr_en && (select_register == rsel_a)) ? s : mem_q[rsel_a];
      end
      if (rd_ok_b) begin
        rb_d = (wr_en && (select_register == rsel_b)) ? s : mem_q[rsel_b];
      end
    end
  end

  // Control and read-data registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      done_q   <= 1'b0;
      w_lost_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      ra_q     <= ra_d;
      rb_q     <= rb_d;
      done_q   <= done_d;
      w_lost_q <= w_lost_d;
    end
  end

  // Storage: reset zeroes every word; the clear engine owns the array while active.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (busy_now) begin
      mem_q[ptr_q] <= '0;
    end else if (wr_en) begin
      mem_q[select_register] <= s;
    end
  end

  assign ra     = ra_q;
  assign rb     = rb_q;
  assign busy   = busy_now;
  assign done   = done_q;
  assign w_lost = w_lost_q;

endmodule

// File: tb/tb_banco_registros_sinc.sv
// Self-checking bench for banco_registros_sinc (N=16, A=4): directed plan steps plus
// random traffic, checked every cycle against a behavioural model.
module tb_banco_registros_sinc;

  localparam int N     = 16;
  localparam int A     = 4;
  localparam int DEPTH = 16;
`ifdef ZERO_REG_HARDWIRED_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, w, clr;
  logic [A-1:0] select_register, rsel_a, rsel_b;
  logic [N-1:0] s;
  logic [N-1:0] ra, rb;
  logic         busy, done, w_lost;

  int total = 0;
  int bad   = 0;

  // Model state: word contents and number of words the clear still has to wipe.
  logic [N-1:0] m_mem [DEPTH];
  int           m_left = 0;
  logic [N-1:0] e_ra, e_rb;
  logic         e_busy, e_done, e_wl;

  banco_registros_sinc #(.N(N), .A(A)) dut (
    .clk             (clk),
    .rst             (rst),
    .w               (w),
    .select_register (select_register),
    .s               (s),
    .rsel_a          (rsel_a),
    .rsel_b          (rsel_b),
    .clr             (clr),
    .ra              (ra),
    .rb              (rb),
    .busy            (busy),
    .done            (done),
    .w_lost          (w_lost)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] rd(input logic [A-1:0] a, input logic wr,
                                      input logic busy_now);
    if (busy_now || (ZR && a == 0)) return '0;
    if (wr && a == select_register) return s;
    return m_mem[a];
  endfunction

  // Advance the model by one edge using the inputs currently driven.
  task automatic model();
    logic busy_now, wr, addr_ok;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_left = 0;
      e_ra = '0; e_rb = '0; e_done = 1'b0; e_wl = 1'b0;
    end else begin
      busy_now = (m_left > 0);
      addr_ok  = !(ZR && select_register == 0);
      wr       = w && !busy_now && addr_ok;
      e_ra     = rd(rsel_a, wr, busy_now);
      e_rb     = rd(rsel_b, wr, busy_now);
      e_wl     = w && busy_now && addr_ok;
      e_done   = (m_left == 1);
      if (busy_now) begin
        m_mem[DEPTH - m_left] = '0;
        m_left--;
      end else if (clr) begin
        m_left = DEPTH;
      end
      if (wr) m_mem[select_register] = s;
    end
    e_busy = (m_left > 0);
  endtask

  task automatic step();
    model();
    @(posedge clk);
    #1;
    chk("ra", ra, e_ra);
    chk("rb", rb, e_rb);
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("w_lost", w_lost, e_wl);
  endtask

  task automatic idle_in();
    rst = 0; w = 0; clr = 0; select_register = 0; s = 0; rsel_a = 0; rsel_b = 0;
  endtask

  initial begin
    int bc;
    idle_in();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 'x;

    // 1. Reset, then write/read.
    rst = 1; step(); rst = 0;
    chk("reset_busy", busy, 0);
    chk("reset_ra", ra, 0);
    w = 1; select_register = 3; s = 16'h00A5; step();
    w = 0; rsel_a = 3; rsel_b = 7; step();
    chk("t1_ra", ra, 16'h00A5);
    chk("t1_rb", rb, 16'h0000);

    // 2. Bypass on both ports.
    w = 1; select_register = 5; s = 16'h1111; step();
    s = 16'hBEEF; rsel_a = 5; rsel_b = 5; step();
    chk("t2_byp_a", ra, 16'hBEEF);
    chk("t2_byp_b", rb, 16'hBEEF);
    w = 0; step();
    chk("t2_mem5", ra, 16'hBEEF);

    // 3. Fill, clear, count busy, read back.
    for (int i = 0; i < DEPTH; i++) begin
      w = 1; select_register = i[A-1:0]; s = 16'hFFFF; rsel_a = i[A-1:0]; step();
    end
    w = 0; clr = 1; step(); clr = 0;
    bc = busy ? 1 : 0;
    for (int k = 0; k < 30; k++) begin
      rsel_a = k[A-1:0]; rsel_b = ~k[A-1:0]; step();
      if (busy) bc++;
    end
    chk("t3_busy_len", bc, DEPTH);
    for (int i = 0; i < DEPTH; i++) begin
      rsel_a = i[A-1:0]; rsel_b = i[A-1:0]; step();
    end
    chk("t3_last_word", ra, 0);

    // 4. Write and second clr during clear.
    for (int i = 0; i < DEPTH; i++) begin
      w = 1; select_register = i[A-1:0]; s = 16'hFFFF; step();
    end
    w = 0; clr = 1; step(); clr = 0;
    bc = busy ? 1 : 0;
    for (int k = 0; k < 30; k++) begin
      w   = (k == 5);
      clr = (k == 8);
      select_register = 15; s = 16'h1234;
      step();
      if (k == 5) chk("t4_w_lost", w_lost, 1);
      if (busy) bc++;
    end
    w = 0; clr = 0;
    chk("t4_busy_len", bc, DEPTH);
    rsel_a = 15; step();
    chk("t4_mem15", ra, 0);

    // 5. Reset in the middle of a clear, then a reset glitch with no edge.
    for (int i = 0; i < DEPTH; i++) begin
      w = 1; select_register = i[A-1:0]; s = 16'h5A5A ^ 16'(i); step();
    end
    w = 0; clr = 1; step(); clr = 0;
    for (int k = 0; k < 5; k++) step();
    rst = 1; step(); rst = 0;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    for (int i = 0; i < DEPTH; i++) begin
      rsel_a = i[A-1:0]; rsel_b = i[A-1:0]; step();
    end
    w = 1; select_register = 9; s = 16'hC0DE; step(); w = 0;
    rsel_a = 9;
    rst = 1; #2; rst = 0;
    step();
    chk("t5_glitch", ra, 16'hC0DE);

    // 6. Address 0 handling (hardwired zero only when the macro is defined).
    w = 1; select_register = 0; s = 16'h7777; rsel_a = 0; rsel_b = 0; step();
    chk("t6_byp0", ra, ZR ? 16'h0000 : 16'h7777);
    w = 0; step();
    chk("t6_rd0", ra, ZR ? 16'h0000 : 16'h7777);
    chk("t6_wl", w_lost, 0);

    // Random traffic.
    for (int k = 0; k < 800; k++) begin
      rst = ($urandom_range(99) == 0);
      clr = ($urandom_range(24) == 0);
      w   = $urandom_range(1);
      select_register = A'($urandom);
      s      = N'($urandom);
      rsel_a = ($urandom_range(3) == 0) ? select_register : A'($urandom);
      rsel_b = ($urandom_range(3) == 0) ? select_register : A'($urandom);
      step();
    end
    idle_in();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/banco_registros_sinc.md
Name: banco_registros_sinc

Overview:
- Parametrised register file of 2^A words × N bits.
- One write port and two registered read ports, each with write-to-read bypass.
- A sequential bulk-clear engine zeroes every word, one word per cycle, with busy/done status.
- Sits between the datapath (ALU result bus `s`) and operand fetch; replaces the fixed 16×16 all-outputs-exposed store with addressed read ports.

Parameters:
- N, 16, data word width in bits (≥1).
- A, 4, address width; DEPTH = 2^A words (A ≥ 1).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- w  input  1  write enable.
- select_register  input  A  write address.
- s  input  N  write data.
- rsel_a  input  A  read port A address.
- rsel_b  input  A  read port B address.
- clr  input  1  bulk-clear request (sampled level, acts on the edge it is seen).
- ra  output  N  read port A data, registered.
- rb  output  N  read port B data, registered.
- busy  output  1  clear engine active.
- done  output  1  one-cycle pulse when clear completes.
- w_lost  output  1  one-cycle pulse when a write was dropped.

Behaviour:
- Clock and reset: single clock `clk`. `rst` is synchronous, active-high, and has priority over every other input.
- Reset values, on a clk edge with rst=1:
  - all DEPTH words = 0
  - ra = 0, rb = 0
  - busy = 0, done = 0, w_lost = 0
  - FSM = IDLE, clear pointer = 0
- A write or clear in flight when reset arrives is abandoned.
- Write:
  - At an edge with w=1, busy=0 and rst=0, mem[select_register] <= s.
  - At an edge with w=1 and busy=1, no write occurs and w_lost=1 for the following cycle only.
- Read:
  - 1-cycle latency: ra <= mem[rsel_a], rb <= mem[rsel_b] at every edge.
  - Bypass: if the same edge performs a write with select_register == rsel_x, ra/rb take s rather than the old word.
  - Both ports may address the same word, including the write address; both then return identical data.
  - While busy=1 at the edge, ra and rb load 0 regardless of address.
- Clear FSM, states IDLE and CLEAR:
  - IDLE: clr=1 → CLEAR, ptr <= 0, busy <= 1. A write with busy=0 in that same cycle is still performed; the clear then wipes it.
  - CLEAR: mem[ptr] <= 0 and ptr <= ptr+1 each edge.
  - CLEAR exit: when ptr == DEPTH-1 the transition is → IDLE, with busy <= 0 and done <= 1 for exactly one cycle.
  - busy is high for exactly DEPTH cycles.
  - clr while in CLEAR is ignored; it neither restarts nor extends the clear.
  - ptr is A bits wide and must not wrap past DEPTH-1 while in CLEAR.
- Arithmetic: no width conversion. s, ra and rb are exactly N bits. Addresses are exactly A bits, so every address is in range.

Optional Feature:
- Macro: ZERO_REG_HARDWIRED_EN.
- Defined:
  - word 0 is constant 0; writes to address 0 are silently discarded, with no w_lost pulse.
  - reads of address 0 return 0, and bypass does not apply to address 0.
  - the clear engine still walks DEPTH cycles.
- Undefined: word 0 is an ordinary storage word.

Test Plan (N=16, A=4):
1. Reset + write/read: rst 1 cycle; w=1, select_register=3, s=0x00A5. Next cycle rsel_a=3 → ra=0x00A5 one edge later. rsel_b=7 → rb=0x0000.
2. Bypass: mem[5]=0x1111; in one cycle w=1, select_register=5, s=0xBEEF, rsel_a=5, rsel_b=5 → after that edge ra=rb=0xBEEF and mem[5]=0xBEEF.
3. Clear sequence:
   - Setup: fill all 16 words with 0xFFFF; pulse clr 1 cycle.
   - Status: busy=1 for exactly 16 cycles; done=1 on the cycle busy falls.
   - Read-back: all 16 words read 0x0000.
   - During busy: ra=rb=0.
4. Write during clear: mid-CLEAR, drive w=1, select_register=15, s=0x1234 → w_lost=1 for one cycle. After done, mem[15]=0x0000. A second clr mid-CLEAR does not extend busy beyond 16 cycles.
5. Sync reset mid-operation:
   - Start clear; assert rst at clear cycle 6 → next cycle busy=0, done=0, ra=rb=0, all words 0.
   - rst asserted between edges without a rising edge has no effect.
6. ZERO_REG_HARDWIRED_EN defined: write select_register=0, s=0x7777 → ra reads 0x0000 with rsel_a=0, including the same-cycle bypass case; w_lost stays 0. Undefined: reads 0x7777.
